// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module   : regfile_pkg
// Brief    : Shared defaults, types and helpers for the multi-port register
//            file and its pending-writeback scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
package regfile_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 6;

    typedef logic [DEF_DATA_W-1:0] reg_data_t;
    typedef logic [DEF_ADDR_W-1:0] reg_addr_t;
    typedef logic [DEF_ADDR_W:0]   pend_cnt_t;

    // Number of registers that can ever be pending (register 0 excluded
    // when it is hardwired to zero).
    function automatic int full_level(input int addr_w, input int zero_reg);
        return (1 << addr_w) - zero_reg;
    endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : regfile_scoreboard
// Brief    : Per-register pending bits for outstanding load writebacks,
//            with set/clear resolution and a running population count.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NUM_WR   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_WR-1:0]              we,
    input  logic [NUM_WR-1:0][ADDR_W-1:0]  wa,
    input  logic                           pend_set,
    input  logic [ADDR_W-1:0]              pend_addr,
    output logic [(2**ADDR_W)-1:0]         pend,
    output logic [ADDR_W:0]                pend_cnt,
    output logic                           pend_full
);

    localparam int DEPTH = 2**ADDR_W;
    localparam logic [ADDR_W:0] c_one  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0] c_full = (ADDR_W+1)'(full_level(ADDR_W, ZERO_REG));

    logic                w_set_ok;
    logic                w_set_new;
    logic [NUM_WR-1:0]   w_wr_ok;
    logic [NUM_WR-1:0]   w_dup;
    logic [DEPTH-1:0]    w_pend_next;
    logic [ADDR_W:0]     w_clr_n;
    logic [ADDR_W:0]     w_cnt_next;

    // Resolve this cycle's set and clears; a set beats a clear on the same
    // register, and two ports clearing one register count as one clear.
    always_comb begin
        w_set_ok    = pend_set && !((ZERO_REG != 0) && (pend_addr == '0));
        w_set_new   = w_set_ok && !pend[pend_addr];
        w_pend_next = pend;
        w_clr_n     = '0;
        w_wr_ok     = '0;
        w_dup       = '0;
        for (int j = 0; j < NUM_WR; j++) begin
            w_wr_ok[j] = we[j] && !((ZERO_REG != 0) && (wa[j] == '0));
        end
        for (int j = 0; j < NUM_WR; j++) begin
            for (int k = j + 1; k < NUM_WR; k++) begin
                if (w_wr_ok[k] && (wa[k] == wa[j])) begin
                    w_dup[j] = 1'b1;
                end
            end
        end
        for (int j = 0; j < NUM_WR; j++) begin
            if (w_wr_ok[j]) begin
                w_pend_next[wa[j]] = 1'b0;
                if (!w_dup[j] && pend[wa[j]] && !(w_set_ok && (pend_addr == wa[j]))) begin
                    w_clr_n = w_clr_n + c_one;
                end
            end
        end
        if (w_set_ok) begin
            w_pend_next[pend_addr] = 1'b1;
        end
        w_cnt_next = pend_cnt - w_clr_n;
        if (w_set_new) begin
            w_cnt_next = w_cnt_next + c_one;
        end
    end

    // Pending bits and their count update together so the count always
    // equals the population of the vector.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend     <= '0;
            pend_cnt <= '0;
        end else begin
            pend     <= w_pend_next;
            pend_cnt <= w_cnt_next;
        end
    end

    assign pend_full = (pend_cnt == c_full);

endmodule
`default_nettype wire

// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
// Module   : regfile_mp
// Brief    : Parametrised multi-port register file with hardwired zero
//            register and pending-writeback scoreboard.
//            Optional macro REGFILE_BYPASS_EN: same-cycle write data is
//            forwarded to matching read ports.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_RD-1:0][ADDR_W-1:0]  ra,
    output logic [NUM_RD-1:0][DATA_W-1:0]  rd,
    output logic [NUM_RD-1:0]              rd_pend,
    input  logic [NUM_WR-1:0]              we,
    input  logic [NUM_WR-1:0][ADDR_W-1:0]  wa,
    input  logic [NUM_WR-1:0][DATA_W-1:0]  wd,
    input  logic                           pend_set,
    input  logic [ADDR_W-1:0]              pend_addr,
    output logic [ADDR_W:0]                pend_cnt,
    output logic                           pend_full
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0]  w_pend;
    logic [NUM_WR-1:0] w_wr_ok;

    // Writes to the hardwired zero register are dropped outright.
    always_comb begin
        w_wr_ok = '0;
        for (int j = 0; j < NUM_WR; j++) begin
            w_wr_ok[j] = we[j] && !((ZERO_REG != 0) && (wa[j] == '0));
        end
    end

    // Storage; ports are applied in ascending order so the highest index wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int n = 0; n < DEPTH; n++) begin
                r_mem[n] <= '0;
            end
        end else begin
            for (int j = 0; j < NUM_WR; j++) begin
                if (w_wr_ok[j]) begin
                    r_mem[wa[j]] <= wd[j];
                end
            end
        end
    end

    regfile_scoreboard #(
        .ADDR_W   (ADDR_W),
        .NUM_WR   (NUM_WR),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .we        (we),
        .wa        (wa),
        .pend_set  (pend_set),
        .pend_addr (pend_addr),
        .pend      (w_pend),
        .pend_cnt  (pend_cnt),
        .pend_full (pend_full)
    );

    generate
        for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
            logic w_is_zero;
            assign w_is_zero = (ZERO_REG != 0) && (ra[i] == '0);

            // Combinational read of stored data and pending bit.
            always_comb begin
                rd[i]      = w_is_zero ? '0   : r_mem[ra[i]];
                rd_pend[i] = w_is_zero ? 1'b0 : w_pend[ra[i]];
`ifdef REGFILE_BYPASS_EN
                if (!rst) begin
                    for (int j = 0; j < NUM_WR; j++) begin
                        if (w_wr_ok[j] && (wa[j] == ra[i])) begin
                            rd[i]      = wd[j];
                            rd_pend[i] = 1'b0;
                        end
                    end
                end
`endif
            end
        end
    endgenerate

endmodule
`default_nettype wire

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port register file for the CPU datapath, successor to the 2-read/1-write file. Adds configurable read/write port counts, a hardwired zero register, a per-register pending scoreboard for outstanding load writebacks, and optional write-to-read bypass. Sits between decode (read ports, scoreboard set) and writeback (write ports).

## Interface
- DATA_W, 32, register width
- ADDR_W, 6, address width; DEPTH = 2**ADDR_W
- NUM_RD, 2, read ports (1..4)
- NUM_WR, 2, write ports (1..2); higher index has priority
- ZERO_REG, 1, 1 = register 0 reads 0, ignores writes and pend_set

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- ra  in  NUM_RD x ADDR_W  read addresses
- rd  out  NUM_RD x DATA_W  read data
- rd_pend  out  NUM_RD  1 = addressed register has an outstanding write
- we  in  NUM_WR  write enables
- wa  in  NUM_WR x ADDR_W  write addresses
- wd  in  NUM_WR x DATA_W  write data
- pend_set  in  1  mark pend_addr as pending
- pend_addr  in  ADDR_W  register to mark
- pend_cnt  out  ADDR_W+1  number of registers currently pending
- pend_full  out  1  pend_cnt == DEPTH-ZERO_REG

## Operation
- Write: on rising edge, for each port with we=1, reg[wa] <= wd. Two ports to same address same cycle: port NUM_WR-1 wins.
- Read: combinational, rd[i] = reg[ra[i]]; ra[i]==0 with ZERO_REG=1 returns 0 regardless of contents.
- Scoreboard: pend[pend_addr] <= 1 on pend_set; pend[wa] <= 0 on any write with we=1.
- Same address set and cleared in one cycle: set wins (newer issue).
- pend_set on an already-pending register: no change, no count change.
- pend_cnt: registered counter, +1 per newly set bit, -1 per newly cleared bit, net of both in one cycle (range -2..+1 per cycle); never wraps, always equals popcount(pend).
- rd_pend[i] = pend[ra[i]], forced 0 for register 0 when ZERO_REG=1.
- Writes to address 0 with ZERO_REG=1: dropped, no scoreboard effect.

## Timing
- Reset (async assert): all registers 0, pend all 0, pend_cnt 0, pend_full 0; rd = 0 for all ports, rd_pend = 0. Reset released synchronously to clk by the system.
- Write latency 1 cycle: data visible on rd the cycle after we (no bypass).
- Scoreboard latency 1 cycle: rd_pend rises the cycle after pend_set.
- Reset asserted mid-operation: in-flight writes and pend_set of that cycle discarded.
- No handshakes; all inputs sampled every cycle.

## Configuration
- REGFILE_BYPASS_EN defined: rd[i] returns the same-cycle wd of the highest-index port with we=1 and wa==ra[i] (address 0 excluded when ZERO_REG=1); rd_pend[i] forced 0 in that case. Bypass inhibited while rst=1.
- Not defined: rd returns stored value only; same-cycle write invisible until next cycle; rd_pend reflects stored pend bit.

## Structure
- regfile_pkg: default DATA_W/ADDR_W localparams, typedefs for reg_addr_t, reg_data_t, pend_cnt_t.
- Sub-module regfile_scoreboard: pend vector, set/clear resolution, pend_cnt, pend_full; regfile_mp instantiates it plus storage and read muxes.

## Test plan
- Reset: write reg 5 = 0xAA, assert rst mid-cycle -> rd for ra=5 is 0 immediately, pend_cnt 0.
- Basic write/read: we[0]=1, wa=1, wd=11; next cycle ra[0]=1, ra[1]=0 -> rd[0]=11, rd[1]=0.
- Write collision: wa[0]=wa[1]=3, wd[0]=7, wd[1]=9 -> reg 3 reads 9; write 0x55 to reg 0 -> reads 0.
- Bypass: same cycle we[1]=1, wa=4, wd=25, ra[0]=4 -> rd[0]=25 with REGFILE_BYPASS_EN, previous value (0) without.
- Scoreboard: pend_set 7 -> next cycle rd_pend=1 on ra=7, pend_cnt 1; write reg 7 with pend_set 8 same cycle -> pend_cnt stays 1; set and write reg 8 same cycle -> stays pending.
- Full: pend_set every address 1..63 -> pend_cnt 63, pend_full 1; pend_set 0 ignored.
